// File: rtl/rtc_write_sequencer.sv
// Writes a snapshot of the edited time/date to the external RTC over its muxed A/D bus.
// Sequence: six BCD register writes, then a commit command. Busy/done are reported to the top level.
module rtc_write_sequencer #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter logic [7:0]  ADDR_SEC     = 8'h21,
  parameter logic [7:0]  ADDR_MIN     = 8'h22,
  parameter logic [7:0]  ADDR_HOUR    = 8'h23,
  parameter logic [7:0]  ADDR_DAY     = 8'h24,
  parameter logic [7:0]  ADDR_MON     = 8'h25,
  parameter logic [7:0]  ADDR_YEAR    = 8'h26,
  parameter logic [7:0]  COMMIT_ADDR  = 8'hF1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic [4:0] day,
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PhaseLoad = 8'(PHASE_CYCLES - 1);
  localparam logic [2:0] LastIndex = 3'd6;

  typedef enum logic [2:0] {
    StIdle, StAddr, StGap1, StData, StGap2, StNext, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [2:0]  index_q, index_d;
  logic        capture;
  logic [5:0]  sec_q, min_q;
  logic [4:0]  hour_q, day_q;
  logic [3:0]  mon_q;
  logic [6:0]  year_q;
  logic [7:0]  cur_addr, cur_data;

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] tens;
    tens = v / 7'd10;
    return {tens[3:0], 4'(v - tens * 7'd10)};
  endfunction

  // Values are saturated at capture so the BCD path only ever sees legal counts.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      phase_q <= 8'd0;
      index_q <= 3'd0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hour_q  <= 5'd0;
      day_q   <= 5'd0;
      mon_q   <= 4'd0;
      year_q  <= 7'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      index_q <= index_d;
      if (capture) begin
        sec_q  <= (seconds > 6'd59) ? 6'd59 : seconds;
        min_q  <= (minutes > 6'd59) ? 6'd59 : minutes;
        hour_q <= (hours > 5'd23) ? 5'd23 : hours;
        day_q  <= day;
        mon_q  <= (month > 4'd12) ? 4'd12 : month;
        year_q <= (year > 7'd99) ? 7'd99 : year;
      end
    end
  end

  always_comb begin
    cur_addr = COMMIT_ADDR;
    cur_data = 8'h00;
    case (index_q)
      3'd0: begin cur_addr = ADDR_SEC;  cur_data = to_bcd({1'b0, sec_q}); end
      3'd1: begin cur_addr = ADDR_MIN;  cur_data = to_bcd({1'b0, min_q}); end
      3'd2: begin cur_addr = ADDR_HOUR; cur_data = to_bcd({2'b0, hour_q}); end
      3'd3: begin cur_addr = ADDR_DAY;  cur_data = to_bcd({2'b0, day_q}); end
      3'd4: begin cur_addr = ADDR_MON;  cur_data = to_bcd({3'b0, mon_q}); end
      3'd5: begin cur_addr = ADDR_YEAR; cur_data = to_bcd(year_q); end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    index_d = index_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAddr;
          index_d = 3'd0;
          capture = 1'b1;
        end
      end
      StAddr: if (phase_q == 8'd0) state_d = StGap1; else phase_d = phase_q - 8'd1;
      StGap1: if (phase_q == 8'd0) state_d = StData; else phase_d = phase_q - 8'd1;
      StData: if (phase_q == 8'd0) state_d = StGap2; else phase_d = phase_q - 8'd1;
      StGap2: if (phase_q == 8'd0) state_d = StNext; else phase_d = phase_q - 8'd1;
      StNext: begin
        if (index_q == LastIndex) begin
          state_d = StDone;
        end else begin
          state_d = StAddr;
          index_d = index_q + 3'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Every state entry restarts the phase timer.
    if (state_d != state_q) phase_d = PhaseLoad;
  end

  always_comb begin
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    a_d    = 1'b1;
    cs_n   = 1'b1;
    wr_n   = 1'b1;
    busy   = 1'b1;
    done   = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StAddr: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = cur_addr;
        cs_n   = 1'b0;
        wr_n   = 1'b0;
      end
      StGap1: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = cur_addr;
      end
      StData: begin
        ad_oe  = 1'b1;
        ad_out = cur_data;
        cs_n   = 1'b0;
        wr_n   = 1'b0;
      end
      StGap2: begin
        ad_oe  = 1'b1;
        ad_out = cur_data;
      end
      StNext: ad_out = cur_data;
      StDone: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign rd_n = 1'b1;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench: a PHASE_CYCLES=2 instance for sequencing/saturation/abort,
// and a PHASE_CYCLES=1 instance for strobe timing.
module tb_rtc_write_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  logic [5:0] seconds = '0, minutes = '0;
  logic [4:0] hours = '0, day = '0;
  logic [3:0] month = '0;
  logic [6:0] year = '0;

  logic [7:0] ad_out, ad_out1;
  logic       ad_oe, a_d, cs_n, wr_n, rd_n, busy, done;
  logic       ad_oe1, a_d1, cs_n1, wr_n1, rd_n1, busy1, done1;

  int passed = 0;
  int total  = 0;

  int rd_bad = 0, stab_bad = 0, wr_pulses = 0, wr_bad = 0, wr_w = 0;
  logic       prev_cs1 = 1'b1, prev_a_d1 = 1'b1;
  logic [7:0] prev_ad1 = 8'h00;

  localparam logic [55:0] Addrs = {8'hF1, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

  always #5 clk = ~clk;

  rtc_write_sequencer #(.PHASE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .seconds(seconds), .minutes(minutes), .hours(hours), .day(day), .month(month), .year(year),
    .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .busy(busy), .done(done)
  );

  rtc_write_sequencer #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .seconds(seconds), .minutes(minutes), .hours(hours), .day(day), .month(month), .year(year),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .a_d(a_d1), .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1),
    .busy(busy1), .done(done1)
  );

  // Mid-cycle bus observers for the strobe-timing and rd_n checks.
  always @(negedge clk) begin
    if (rd_n !== 1'b1 || rd_n1 !== 1'b1) rd_bad++;
    if (cs_n1 === 1'b0 && prev_cs1 === 1'b0 && (ad_out1 !== prev_ad1 || a_d1 !== prev_a_d1))
      stab_bad++;
    if (wr_n1 === 1'b0) begin
      wr_w++;
    end else if (wr_w != 0) begin
      wr_pulses++;
      if (wr_w != 1) wr_bad++;
      wr_w = 0;
    end
    prev_cs1  = cs_n1;
    prev_ad1  = ad_out1;
    prev_a_d1 = a_d1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ad_out"}, 32'(ad_out), 32'h00);
    check({tag, " ad_oe"}, 32'(ad_oe), 32'd0);
    check({tag, " a_d"}, 32'(a_d), 32'd1);
    check({tag, " cs_n"}, 32'(cs_n), 32'd1);
    check({tag, " wr_n"}, 32'(wr_n), 32'd1);
    check({tag, " rd_n"}, 32'(rd_n), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
  endtask

  // Start on the P=2 instance and check every transaction; PHASE_CYCLES=2 gives 9 cycles each.
  task automatic run_seq(input string tag, input logic [55:0] exp_data, input bit disturb);
    int k, r;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 75; c++) begin
      if (c > 1) tick();
      check({tag, " busy"}, 32'(busy), 32'(c <= 63));
      check({tag, " done"}, 32'(done), 32'(c == 64));
      if (c <= 63) begin
        k = (c - 1) / 9;
        r = (c - 1) % 9;
        if (r == 0) begin
          check({tag, " addr"}, 32'(ad_out), 32'(Addrs[8*k +: 8]));
          check({tag, " addr a_d"}, 32'(a_d), 32'd0);
          check({tag, " addr strobes"}, 32'({cs_n, wr_n, ad_oe}), 32'b001);
        end else if (r == 2) begin
          check({tag, " gap1 strobes"}, 32'({cs_n, wr_n}), 32'b11);
          check({tag, " gap1 addr held"}, 32'(ad_out), 32'(Addrs[8*k +: 8]));
        end else if (r == 4) begin
          check({tag, " data"}, 32'(ad_out), 32'(exp_data[8*k +: 8]));
          check({tag, " data a_d"}, 32'(a_d), 32'd1);
          check({tag, " data strobes"}, 32'({cs_n, wr_n, ad_oe}), 32'b001);
        end else if (r == 8) begin
          check({tag, " next ad_oe"}, 32'(ad_oe), 32'd0);
        end
      end else if (c > 64) begin
        check({tag, " quiet after"}, 32'({cs_n, wr_n}), 32'b11);
      end
      if (disturb) begin
        if (c == 2) begin
          seconds = 6'd1; minutes = 6'd2; hours = 5'd3; day = 5'd4; month = 4'd5; year = 7'd6;
        end
        start = (c == 10 || c == 40);
      end
    end
  endtask

  initial begin
    int dcount;
    // Reset
    reset = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b1;

    // Idle: no start, strobes stay high
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cs_n !== 1'b1 || wr_n !== 1'b1 || busy !== 1'b0) dcount++;
    end
    check("idle quiet", 32'(dcount), 32'd0);

    // Nominal sequence
    seconds = 6'd45; minutes = 6'd30; hours = 5'd13; day = 5'd22; month = 4'd7; year = 7'd16;
    run_seq("nominal", {8'h00, 8'h16, 8'h07, 8'h22, 8'h13, 8'h30, 8'h45}, 1'b0);

    // Saturation
    seconds = 6'd63; minutes = 6'd60; hours = 5'd31; day = 5'd5; month = 4'd15; year = 7'd120;
    run_seq("saturate", {8'h00, 8'h99, 8'h12, 8'h05, 8'h23, 8'h59, 8'h59}, 1'b0);

    // Hold: extra starts and input changes mid-sequence must be ignored
    seconds = 6'd45; minutes = 6'd30; hours = 5'd13; day = 5'd22; month = 4'd7; year = 7'd16;
    run_seq("hold", {8'h00, 8'h16, 8'h07, 8'h22, 8'h13, 8'h30, 8'h45}, 1'b1);
    start = 1'b0;

    // Abort during DATA of index 3 (cycle 32)
    seconds = 6'd45; minutes = 6'd30; hours = 5'd13; day = 5'd22; month = 4'd7; year = 7'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 32; c++) tick();
    check("abort pre data", 32'(ad_out), 32'h22);
    check("abort pre strobes", 32'({a_d, cs_n, wr_n}), 32'b100);
    reset = 1'b0;
    tick();
    check_reset_outputs("abort");
    reset = 1'b1;
    dcount = 0;
    for (int i = 0; i < 130; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
    end
    check("abort no done", 32'(dcount), 32'd0);
    run_seq("after abort", {8'h00, 8'h16, 8'h07, 8'h22, 8'h13, 8'h30, 8'h45}, 1'b0);

    // Strobe timing on the PHASE_CYCLES=1 instance: done at 7*5+1 = 36
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dcount = 0;
    for (int c = 1; c <= 45; c++) begin
      if (c > 1) tick();
      if (done1 !== 1'(c == 36)) dcount++;
      if (busy1 !== 1'(c <= 35)) dcount++;
    end
    check("p1 busy/done timing", 32'(dcount), 32'd0);
    check("p1 wr pulses", 32'(wr_pulses), 32'd14);
    check("p1 wr width", 32'(wr_bad), 32'd0);
    check("p1 bus stable under cs", 32'(stab_bad), 32'd0);
    check("rd_n always high", 32'(rd_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
